// File: rtl/huffman_coding_if.sv
// rtl/huffman_coding_if.sv - symbol input and serial code-table output bundle
// Purpose: groups the sample input handshake and the serial code-table stream
//          of the Huffman encoder core.
// Signals:
//   data_in      4-bit input symbol (0..9 counted, 10..15 ignored)
//   start        1-cycle block start pulse
//   output_start 1-cycle pulse opening the serial table
//   output_data  serial code bit, qualified by code_en
//   code_en      output_data valid
//   data_select  symbol whose code is on output_data
//   output_gap   1-cycle separator between symbol codes
//   output_done  1-cycle pulse after the last code bit
// Modports: master drives data_in/start (producer/consumer side),
//           slave is the encoder core.
interface huffman_coding_if;
   logic [3:0] data_in;
   logic       start;
   logic       output_start;
   logic       output_data;
   logic       code_en;
   logic [3:0] data_select;
   logic       output_gap;
   logic       output_done;

   modport master (
      output data_in, start,
      input  output_start, output_data, code_en, data_select, output_gap, output_done
   );

   modport slave (
      input  data_in, start,
      output output_start, output_data, code_en, data_select, output_gap, output_done
   );
endinterface

// File: rtl/huffman_coding.sv
// rtl/huffman_coding.sv - symbol frequency counter, Huffman tree builder and serial code-table emitter
// Purpose: counts N_SAMPLES 4-bit symbols, merges one Huffman node per clock
//          (9 merges for 10 leaves) and serially emits the code of each symbol.
// Ports:
//   clk                 rising-edge clock
//   rst_n               asynchronous reset, ACTIVE HIGH (1 = reset) despite the name
//   bus                 huffman_coding_if.slave: data_in/start in, serial table out
//   code_0..code_9      right-aligned codes, bit len-1 is the root-side bit
//   min1, min2          selected node indices while building, 0 otherwise
//   data_count_finish   level, counting done
//   encoding_finish     level, codes valid
//   huffman_out_finish  level, table fully emitted
// Optional feature: define CODE_LEN_OUT_EN to add code_len_0..code_len_9 ports.
module huffman_coding #(
   parameter int N_SAMPLES = 256,
   parameter int CNT_W     = 9
) (
   input  logic             clk,
   input  logic             rst_n,
   huffman_coding_if.slave  bus,
   output logic [8:0]       code_0,
   output logic [8:0]       code_1,
   output logic [8:0]       code_2,
   output logic [8:0]       code_3,
   output logic [8:0]       code_4,
   output logic [8:0]       code_5,
   output logic [8:0]       code_6,
   output logic [8:0]       code_7,
   output logic [8:0]       code_8,
   output logic [8:0]       code_9,
   output logic [4:0]       min1,
   output logic [4:0]       min2,
   output logic             data_count_finish,
   output logic             encoding_finish,
   output logic             huffman_out_finish
`ifdef CODE_LEN_OUT_EN
   ,
   output logic [3:0]       code_len_0,
   output logic [3:0]       code_len_1,
   output logic [3:0]       code_len_2,
   output logic [3:0]       code_len_3,
   output logic [3:0]       code_len_4,
   output logic [3:0]       code_len_5,
   output logic [3:0]       code_len_6,
   output logic [3:0]       code_len_7,
   output logic [3:0]       code_len_8,
   output logic [3:0]       code_len_9
`endif
);
   localparam int IDX_W = (N_SAMPLES > 1) ? $clog2(N_SAMPLES) : 1;

   typedef enum logic [1:0] {IDLE, COUNT, BUILD, OUT} state_t;
   state_t state;

   logic [IDX_W-1:0] idx;
   logic [CNT_W-1:0] cnt [10];
   logic [CNT_W-1:0] iw  [9];    // internal node weights (nodes 10..18)
   logic [9:0]       im  [9];    // internal node leaf masks
   logic [18:0]      active;
   logic [8:0]       code [10];
   logic [3:0]       len  [10];
   logic [3:0]       step;
   logic [3:0]       sym;
   logic [3:0]       bidx;       // bits of the current symbol already emitted

   // Unified node view: leaves take their weight straight from the counters.
   logic [CNT_W-1:0] nw [19];
   logic [9:0]       nm [19];
   always_comb begin
      for (int i = 0; i < 19; i++) begin
         if (i < 10) begin
            nw[i] = cnt[i];
            nm[i] = 10'b1 << i;
         end else begin
            nw[i] = iw[i-10];
            nm[i] = im[i-10];
         end
      end
   end

   // Strict less-than while scanning upward gives ties to the lower index.
   logic [4:0]       sel1, sel2;
   logic             found;
   logic [CNT_W-1:0] best;
   always_comb begin
      sel1  = '0;
      sel2  = '0;
      found = 1'b0;
      best  = '0;
      for (int i = 0; i < 19; i++) begin
         if (active[i] && (!found || nw[i] < best)) begin
            found = 1'b1;
            best  = nw[i];
            sel1  = 5'(i);
         end
      end
      found = 1'b0;
      best  = '0;
      for (int i = 0; i < 19; i++) begin
         if (active[i] && (5'(i) != sel1) && (!found || nw[i] < best)) begin
            found = 1'b1;
            best  = nw[i];
            sel2  = 5'(i);
         end
      end
   end

   assign min1 = (state == BUILD) ? sel1 : 5'd0;
   assign min2 = (state == BUILD) ? sel2 : 5'd0;

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state              <= IDLE;
         idx                <= '0;
         active             <= '0;
         step               <= '0;
         sym                <= '0;
         bidx               <= '0;
         data_count_finish  <= 1'b0;
         encoding_finish    <= 1'b0;
         huffman_out_finish <= 1'b0;
         bus.output_start   <= 1'b0;
         bus.output_data    <= 1'b0;
         bus.code_en        <= 1'b0;
         bus.data_select    <= '0;
         bus.output_gap     <= 1'b0;
         bus.output_done    <= 1'b0;
         for (int j = 0; j < 10; j++) begin
            cnt[j]  <= '0;
            code[j] <= '0;
            len[j]  <= '0;
         end
         for (int j = 0; j < 9; j++) begin
            iw[j] <= '0;
            im[j] <= '0;
         end
      end else begin
         bus.output_start <= 1'b0;
         bus.output_data  <= 1'b0;
         bus.code_en      <= 1'b0;
         bus.data_select  <= '0;
         bus.output_gap   <= 1'b0;
         bus.output_done  <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  state              <= COUNT;
                  idx                <= '0;
                  active             <= '0;
                  data_count_finish  <= 1'b0;
                  encoding_finish    <= 1'b0;
                  huffman_out_finish <= 1'b0;
                  for (int j = 0; j < 10; j++) begin
                     cnt[j]  <= '0;
                     code[j] <= '0;
                     len[j]  <= '0;
                  end
               end
            end
            COUNT: begin
               if (bus.data_in < 4'd10)
                  cnt[bus.data_in] <= cnt[bus.data_in] + CNT_W'(1);
               idx <= idx + IDX_W'(1);
               if (idx == IDX_W'(N_SAMPLES - 1)) begin
                  data_count_finish <= 1'b1;
                  active            <= 19'h003FF;
                  step              <= '0;
                  state             <= BUILD;
               end
            end
            BUILD: begin
               iw[step]                  <= nw[sel1] + nw[sel2];
               im[step]                  <= nm[sel1] | nm[sel2];
               active[sel1]              <= 1'b0;
               active[sel2]              <= 1'b0;
               active[5'd10 + 5'(step)]  <= 1'b1;
               // Codes start cleared, so a 0 bit only needs the length bump.
               for (int j = 0; j < 10; j++) begin
                  if (nm[sel1][j]) begin
                     len[j] <= len[j] + 4'd1;
                  end else if (nm[sel2][j]) begin
                     code[j][len[j]] <= 1'b1;
                     len[j]          <= len[j] + 4'd1;
                  end
               end
               step <= step + 4'd1;
               if (step == 4'd8) begin
                  encoding_finish  <= 1'b1;
                  bus.output_start <= 1'b1;
                  sym              <= '0;
                  bidx             <= '0;
                  state            <= OUT;
               end
            end
            OUT: begin
               // Outputs are registered: each edge decides the next cycle's slot.
               if (bus.output_done) begin
                  huffman_out_finish <= 1'b1;
                  state              <= IDLE;
               end else if (bus.output_start || bus.output_gap) begin
                  bus.code_en     <= 1'b1;
                  bus.data_select <= sym;
                  bus.output_data <= code[sym][len[sym] - 4'd1];
                  bidx            <= 4'd1;
               end else if (bidx == len[sym]) begin
                  if (sym == 4'd9) begin
                     bus.output_done <= 1'b1;
                  end else begin
                     bus.output_gap <= 1'b1;
                     sym            <= sym + 4'd1;
                     bidx           <= '0;
                  end
               end else begin
                  bus.code_en     <= 1'b1;
                  bus.data_select <= sym;
                  bus.output_data <= code[sym][len[sym] - 4'd1 - bidx];
                  bidx            <= bidx + 4'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign code_0 = code[0];
   assign code_1 = code[1];
   assign code_2 = code[2];
   assign code_3 = code[3];
   assign code_4 = code[4];
   assign code_5 = code[5];
   assign code_6 = code[6];
   assign code_7 = code[7];
   assign code_8 = code[8];
   assign code_9 = code[9];

`ifdef CODE_LEN_OUT_EN
   assign code_len_0 = len[0];
   assign code_len_1 = len[1];
   assign code_len_2 = len[2];
   assign code_len_3 = len[3];
   assign code_len_4 = len[4];
   assign code_len_5 = len[5];
   assign code_len_6 = len[6];
   assign code_len_7 = len[7];
   assign code_len_8 = len[8];
   assign code_len_9 = len[9];
`endif
endmodule

// File: tb/tb_huffman_coding.sv
// tb/tb_huffman_coding.sv - directed scoreboard bench for huffman_coding
module tb_huffman_coding;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   huffman_coding_if bus();

   logic [8:0] dc [10];
   logic [4:0] min1, min2;
   logic       dcf, ef, hof;
`ifdef CODE_LEN_OUT_EN
   logic [3:0] dl [10];
`endif

   huffman_coding #(.N_SAMPLES(256), .CNT_W(9)) dut (
      .clk(clk), .rst_n(rst_n), .bus(bus),
      .code_0(dc[0]), .code_1(dc[1]), .code_2(dc[2]), .code_3(dc[3]), .code_4(dc[4]),
      .code_5(dc[5]), .code_6(dc[6]), .code_7(dc[7]), .code_8(dc[8]), .code_9(dc[9]),
      .min1(min1), .min2(min2),
      .data_count_finish(dcf), .encoding_finish(ef), .huffman_out_finish(hof)
`ifdef CODE_LEN_OUT_EN
      ,
      .code_len_0(dl[0]), .code_len_1(dl[1]), .code_len_2(dl[2]), .code_len_3(dl[3]),
      .code_len_4(dl[4]), .code_len_5(dl[5]), .code_len_6(dl[6]), .code_len_7(dl[7]),
      .code_len_8(dl[8]), .code_len_9(dl[9])
`endif
   );

   typedef struct {
      logic [3:0] sym;
      logic       bitv;
   } exp_t;

   int         n_vec = 0;
   int         n_err = 0;
   logic [3:0] samp [256];
   int         mcnt [10];
   logic [8:0] mcode [10];
   int         mlen [10];
   int         mmin1 [9];
   int         mmin2 [9];
   int         omin1 [9];
   int         omin2 [9];
   logic [8:0] rx_code [10];
   int         rx_len [10];
   exp_t       q [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference Huffman construction from the sample buffer.
   task automatic model();
      int         w [19];
      logic [9:0] m [19];
      bit         act [19];
      int         a, b;
      for (int i = 0; i < 10; i++) begin
         mcnt[i] = 0; mcode[i] = '0; mlen[i] = 0;
      end
      for (int i = 0; i < 256; i++)
         if (samp[i] < 10) mcnt[samp[i]]++;
      for (int i = 0; i < 19; i++) begin
         w[i]   = (i < 10) ? mcnt[i] : 0;
         m[i]   = (i < 10) ? (10'b1 << i) : 10'b0;
         act[i] = (i < 10);
      end
      for (int k = 0; k < 9; k++) begin
         a = -1; b = -1;
         for (int i = 0; i < 19; i++)
            if (act[i] && (a < 0 || w[i] < w[a])) a = i;
         for (int i = 0; i < 19; i++)
            if (act[i] && i != a && (b < 0 || w[i] < w[b])) b = i;
         mmin1[k] = a; mmin2[k] = b;
         for (int j = 0; j < 10; j++) begin
            if (m[a][j]) mlen[j]++;
            else if (m[b][j]) begin
               mcode[j][mlen[j]] = 1'b1;
               mlen[j]++;
            end
         end
         w[10+k] = w[a] + w[b];
         m[10+k] = m[a] | m[b];
         act[a] = 0; act[b] = 0; act[10+k] = 1;
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, ":dcf"}, dcf, 0);
      check({tag, ":ef"}, ef, 0);
      check({tag, ":hof"}, hof, 0);
      check({tag, ":min1"}, min1, 0);
      check({tag, ":min2"}, min2, 0);
      check({tag, ":ostart"}, bus.output_start, 0);
      check({tag, ":odata"}, bus.output_data, 0);
      check({tag, ":code_en"}, bus.code_en, 0);
      check({tag, ":dsel"}, bus.data_select, 0);
      check({tag, ":gap"}, bus.output_gap, 0);
      check({tag, ":done"}, bus.output_done, 0);
      for (int s = 0; s < 10; s++) begin
         check($sformatf("%s:code_%0d", tag, s), dc[s], 0);
`ifdef CODE_LEN_OUT_EN
         check($sformatf("%s:len_%0d", tag, s), dl[s], 0);
`endif
      end
   endtask

   task automatic run_block(input string tag);
      int   cyc, en_cyc, sumlen, gaps, bad_idle;
      bit   done;
      exp_t e;
      model();
      q.delete();
      sumlen = 0;
      for (int s = 0; s < 10; s++) begin
         for (int i = 0; i < mlen[s]; i++) begin
            e.sym  = 4'(s);
            e.bitv = mcode[s][mlen[s]-1-i];
            q.push_back(e);
         end
         sumlen += mlen[s];
      end
      @(posedge clk); #1 bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
      for (int i = 0; i < 256; i++) begin
         bus.data_in = samp[i];
         if (i == 255) begin
            @(negedge clk);
            check({tag, ":dcf_before_last"}, dcf, 0);
         end
         @(posedge clk); #1;
      end
      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
         if (k == 0) check({tag, ":dcf_after_last"}, dcf, 1);
         omin1[k] = int'(min1);
         omin2[k] = int'(min2);
         check($sformatf("%s:min1_%0d", tag, k), min1, mmin1[k]);
         check($sformatf("%s:min2_%0d", tag, k), min2, mmin2[k]);
         if (k == 8) check({tag, ":ef_before"}, ef, 0);
         @(posedge clk);
      end
      @(negedge clk);
      check({tag, ":ef_9_after"}, ef, 1);
      check({tag, ":output_start"}, bus.output_start, 1);
      check({tag, ":min1_out"}, min1, 0);
      for (int s = 0; s < 10; s++) begin
         check($sformatf("%s:code_%0d", tag, s), dc[s], mcode[s]);
`ifdef CODE_LEN_OUT_EN
         check($sformatf("%s:len_%0d", tag, s), dl[s], mlen[s]);
`endif
         rx_code[s] = '0;
         rx_len[s]  = 0;
      end
      cyc = 1; en_cyc = 0; gaps = 0; bad_idle = 0; done = 0;
      while (!done && cyc < 400) begin
         @(negedge clk);
         cyc++;
         if (bus.code_en) begin
            en_cyc++;
            if (bus.data_select < 10) begin
               rx_code[bus.data_select] = {rx_code[bus.data_select][7:0], bus.output_data};
               rx_len[bus.data_select]++;
            end
            if (q.size() == 0) begin
               check({tag, ":extra_bit"}, 1, 0);
            end else begin
               e = q.pop_front();
               check({tag, ":bit_sym"}, bus.data_select, e.sym);
               check({tag, ":bit_val"}, bus.output_data, e.bitv);
            end
         end else begin
            if (bus.data_select !== 4'd0 || bus.output_data !== 1'b0) bad_idle++;
            if (bus.output_gap) gaps++;
            if (bus.output_done) done = 1;
         end
      end
      check({tag, ":done_seen"}, done, 1);
      check({tag, ":out_cycles"}, cyc, 1 + sumlen + 9 + 1);
      check({tag, ":en_cycles"}, en_cyc, sumlen);
      check({tag, ":gaps"}, gaps, 9);
      check({tag, ":queue_left"}, q.size(), 0);
      check({tag, ":idle_zero"}, bad_idle, 0);
      @(negedge clk);
      check({tag, ":hof"}, hof, 1);
   endtask

   initial begin
      int kr, pv, lbad;
      rst_n = 1'b1;
      bus.start = 1'b0;
      bus.data_in = 4'd0;
      repeat (3) @(posedge clk);
      #1 bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
      @(negedge clk);
      check_zero("reset");
      rst_n = 1'b0;
      repeat (300) @(negedge clk);
      check_zero("idle_after_reset");

      for (int i = 0; i < 256; i++) samp[i] = 4'd3;
      run_block("all3");
      check("all3:first_min1", omin1[0], 0);
      check("all3:first_min2", omin2[0], 1);
      check("all3:last_min1", omin1[8], 17);
      check("all3:last_min2", omin2[8], 3);
      check("all3:code_3", dc[3], 9'b000000001);
      check("all3:len_3", rx_len[3], 1);

      for (int i = 0; i < 256; i++) samp[i] = 4'(i % 10);
      run_block("cyc10");
      kr = 0; pv = 0; lbad = 0;
      for (int a = 0; a < 10; a++) begin
         if (rx_len[a] != 3 && rx_len[a] != 4) lbad++;
         kr += 1 << (9 - rx_len[a]);
         for (int b = 0; b < 10; b++)
            if (a != b && rx_len[a] > 0 && rx_len[a] <= rx_len[b] &&
                (rx_code[b] >> (rx_len[b] - rx_len[a])) == rx_code[a]) pv++;
      end
      check("cyc10:len_3_or_4", lbad, 0);
      check("cyc10:kraft", kr, 512);
      check("cyc10:prefix_free", pv, 0);

      for (int i = 0; i < 256; i++)
         samp[i] = (i % 3 == 0) ? 4'd12 : (i % 3 == 1) ? 4'd15 : 4'((i * 7) % 10);
      run_block("oor");

      for (int i = 0; i < 256; i++) samp[i] = 4'(i % 10);
      @(posedge clk); #1 bus.start = 1'b1;
      @(posedge clk); #1 bus.start = 1'b0;
      for (int i = 0; i < 100; i++) begin
         bus.data_in = samp[i];
         @(posedge clk); #1;
      end
      rst_n = 1'b1;
      @(negedge clk);
      check_zero("mid_reset");
      @(posedge clk); #1 rst_n = 1'b0;
      run_block("after_reset");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
